// File: rtl/pixel_window_serializer.sv
// Replays a captured TAPS-pixel window one pixel per beat on a valid/ready stream,
// oldest tap first, with zero-bubble back-to-back reload and synchronous flush.
module pixel_window_serializer #(
    parameter int unsigned PIX_W = 24,
    parameter int unsigned TAPS  = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PIX_W*TAPS-1:0] taps_in,
    input  logic                  load,
    output logic                  load_ready,
    input  logic                  flush,
    output logic [PIX_W-1:0]      pixel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);
    localparam int unsigned IDX_W = $clog2(TAPS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(TAPS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                   state, state_n;
    logic [IDX_W-1:0]         idx, idx_n, idx_dec;
    logic [TAPS-1:0][PIX_W-1:0] buffer;
    logic [PIX_W-1:0]         pix_n;
    logic                     valid_n, last_n, busy_n, capture;

    // Packed buffer shares taps_in's layout, so buffer[k] is tap k.
    assign idx_dec    = idx - IDX_W'(1);
    assign load_ready = (state == IDLE) |
                        ((state == SEND) & (idx == '0) & out_ready & ~flush);

    // Next-state and next-output decode; flush overrides load and beat accept.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        pix_n   = pixel_out;
        valid_n = out_valid;
        last_n  = out_last;
        capture = 1'b0;
        if (flush) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) capture = 1'b1;
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx != '0) begin
                            idx_n  = idx_dec;
                            pix_n  = buffer[idx_dec];
                            last_n = (idx_dec == '0);
                        end else if (load) begin
                            capture = 1'b1;
                        end else begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
            if (capture) begin
                state_n = SEND;
                idx_n   = IDX_TOP;
                pix_n   = taps_in[(TAPS-1)*PIX_W +: PIX_W];
                valid_n = 1'b1;
                last_n  = 1'b0;
            end
        end
        busy_n = (state_n == SEND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            buffer    <= '0;
            pixel_out <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pixel_out <= pix_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= busy_n;
            if (capture) buffer <= taps_in;
        end
    end

endmodule

// File: tb/tb_pixel_window_serializer.sv
// Scoreboard bench for pixel_window_serializer: expected beats are queued on each
// accepted load and compared against the stream while the window drains.
module tb_pixel_window_serializer;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned TAPS  = 11;
    localparam int unsigned IDX_W = $clog2(TAPS);

    typedef logic [TAPS-1:0][PIX_W-1:0] win_t;
    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n;
    win_t             taps_in;
    logic             load, flush, out_ready;
    logic             load_ready, out_valid, out_last, busy;
    logic [PIX_W-1:0] pixel_out;

    int    tests = 0;
    int    fails = 0;
    beat_t q[$];
    logic  m_send = 1'b0;
    int    m_idx  = 0;
    int    beats  = 0;

    pixel_window_serializer #(.PIX_W(PIX_W), .TAPS(TAPS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .taps_in    (taps_in),
        .load       (load),
        .load_ready (load_ready),
        .flush      (flush),
        .pixel_out  (pixel_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic win_t mk_win(input logic [PIX_W-1:0] base, input logic [PIX_W-1:0] step);
        win_t w;
        for (int k = 0; k < int'(TAPS); k++) w[IDX_W'(k)] = base + PIX_W'(k) * step;
        return w;
    endfunction

    task automatic push_window(input win_t w);
        for (int k = int'(TAPS) - 1; k >= 0; k--) q.push_back({w[IDX_W'(k)], (k == 0)});
        m_send = 1'b1;
        m_idx  = int'(TAPS) - 1;
    endtask

    // One cycle from a negedge: drive inputs, check against the model, advance the model.
    task automatic drive(input logic ld, input logic fl, input logic rdy, input win_t tp);
        logic exp_lr;
        load = ld; flush = fl; out_ready = rdy; taps_in = tp;
        #1;
        exp_lr = !m_send || (m_idx == 0 && rdy && !fl);
        tests++;
        if (load_ready !== exp_lr) begin
            fails++; $display("FAIL load_ready: got %b expected %b", load_ready, exp_lr);
        end
        tests++;
        if (out_valid !== m_send || busy !== m_send) begin
            fails++; $display("FAIL valid_busy: got valid=%b busy=%b expected %b", out_valid, busy, m_send);
        end
        if (m_send) begin
            tests++;
            if (q.size() == 0) begin
                fails++; $display("FAIL scoreboard: beat presented with empty queue");
            end else if (pixel_out !== q[0].pix || out_last !== q[0].last) begin
                fails++; $display("FAIL beat: got pix=%h last=%b expected pix=%h last=%b",
                                  pixel_out, out_last, q[0].pix, q[0].last);
            end
        end
        if (fl) begin
            m_send = 1'b0;
            q.delete();
        end else if (!m_send) begin
            if (ld) push_window(tp);
        end else if (rdy) begin
            void'(q.pop_front());
            beats++;
            if (m_idx == 0) begin
                if (ld) push_window(tp);
                else m_send = 1'b0;
            end else begin
                m_idx--;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (m_send && n < budget) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            n++;
        end
        tests++;
        if (m_send) begin
            fails++; $display("FAIL drain_timeout: still busy after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 0; flush = 0; out_ready = 0; taps_in = '0;
        @(negedge clk); @(negedge clk);
        tests++;
        if ({pixel_out, out_valid, out_last, busy} !== '0 || load_ready !== 1'b1) begin
            fails++; $display("FAIL reset_idle: got pix=%h v=%b l=%b b=%b lr=%b expected 0/0/0/0/1",
                              pixel_out, out_valid, out_last, busy, load_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, mk_win(24'h123456, 24'h000111));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, '0);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({pixel_out, out_valid, out_last, busy} !== '0) begin
            fails++; $display("FAIL reset_midsend: got pix=%h v=%b l=%b b=%b expected all 0",
                              pixel_out, out_valid, out_last, busy);
        end
        q.delete(); m_send = 1'b0; m_idx = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_release: got lr=%b busy=%b valid=%b expected 1/0/0",
                              load_ready, busy, out_valid);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic test_basic();
        beats = 0;
        drive(1'b1, 1'b0, 1'b1, mk_win(24'h000000, 24'h000010));
        tests++;
        if (out_valid !== 1'b1 || pixel_out !== 24'h0000A0) begin
            fails++; $display("FAIL basic_latency: got valid=%b pix=%h expected 1 0000a0", out_valid, pixel_out);
        end
        drain(50);
        tests++;
        if (beats != int'(TAPS) || busy !== 1'b0) begin
            fails++; $display("FAIL basic_count: got beats=%0d busy=%b expected %0d 0", beats, busy, TAPS);
        end
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   n = 0;
        beats = 0;
        drive(1'b1, 1'b0, 1'b0, mk_win(PIX_W'($urandom), PIX_W'($urandom)));
        while (m_send && n < 200) begin
            drive(1'b0, 1'b0, pat[n % 4], '0);
            n++;
        end
        tests++;
        if (beats != int'(TAPS) || m_send) begin
            fails++; $display("FAIL backpressure_count: got beats=%0d expected %0d", beats, TAPS);
        end
    endtask

    task automatic test_back_to_back();
        win_t a = mk_win(24'hA00000, 24'h000101);
        win_t b = mk_win(24'hB00000, 24'h010001);
        int   n = 0;
        int   valid_cycles = 0;
        logic second = 1'b0;
        beats = 0;
        drive(1'b1, 1'b0, 1'b1, a);
        while (m_send && n < 100) begin
            if (!second && m_idx == 0) begin
                second = 1'b1;
                drive(1'b1, 1'b0, 1'b1, b);
            end else begin
                drive(!second, 1'b0, 1'b1, a);
            end
            valid_cycles++;
            n++;
        end
        tests++;
        if (beats != 2 * int'(TAPS) || valid_cycles != 2 * int'(TAPS)) begin
            fails++; $display("FAIL back_to_back: got beats=%0d cycles=%0d expected %0d", beats, valid_cycles, 2 * TAPS);
        end
    endtask

    task automatic test_flush();
        beats = 0;
        drive(1'b1, 1'b0, 1'b1, mk_win(24'hF00000, 24'h000003));
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b1, mk_win(24'hDEAD00, 24'h000001));
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || load_ready !== 1'b1) begin
            fails++; $display("FAIL flush_idle: got v=%b b=%b l=%b lr=%b expected 0/0/0/1",
                              out_valid, busy, out_last, load_ready);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, '0);
        beats = 0;
        drive(1'b1, 1'b0, 1'b1, mk_win(24'h0C0000, 24'h000020));
        tests++;
        if (pixel_out !== 24'h0C0140) begin
            fails++; $display("FAIL flush_restart: got pix=%h expected 0c0140", pixel_out);
        end
        drain(50);
        tests++;
        if (beats != int'(TAPS)) begin
            fails++; $display("FAIL flush_count: got beats=%0d expected %0d", beats, TAPS);
        end
    endtask

    task automatic test_ignored_load();
        beats = 0;
        drive(1'b1, 1'b0, 1'b1, mk_win(24'h555000, 24'h000007));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, '0);
        tests++;
        if (load_ready !== 1'b0) begin
            fails++; $display("FAIL ignored_lr: got load_ready=%b expected 0", load_ready);
        end
        drive(1'b1, 1'b0, 1'b1, mk_win(24'hBAD000, 24'h000001));
        drain(50);
        tests++;
        if (beats != int'(TAPS) || busy !== 1'b0) begin
            fails++; $display("FAIL ignored_done: got beats=%0d busy=%b expected %0d 0", beats, busy, TAPS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_ignored_load();
        drive(1'b0, 1'b0, 1'b1, '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
